// File: rtl/hazard_ctrl_if.sv
// Hazard unit bundle: pipeline hazard inputs and sequencer controls.
// HAZ_PERF_CNT_EN adds the stall_cnt signal.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic [REG_W-1:0] rs_e;
  logic [REG_W-1:0] rt_e;
  logic [REG_W-1:0] wreg_e;
  logic [REG_W-1:0] wreg_m;
  logic [REG_W-1:0] wreg_w;
  logic             regwr_e;
  logic             regwr_m;
  logic             regwr_w;
  logic             memtoreg_e;
  logic             memtoreg_m;
  logic             branch_d;
  logic             taken_d;
  logic             md_op_e;
  logic             md_done;
  logic             exc_m;
  logic             fwd_a_d;
  logic             fwd_b_d;
  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic             md_start;
  logic             md_abort;
  logic             md_err;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  modport master (
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt,
`endif
    output rs_d, rt_d, rs_e, rt_e,
    output wreg_e, wreg_m, wreg_w,
    output regwr_e, regwr_m, regwr_w,
    output memtoreg_e, memtoreg_m,
    output branch_d, taken_d,
    output md_op_e, md_done, exc_m,
    input  fwd_a_d, fwd_b_d,
    input  fwd_a_e, fwd_b_e,
    input  stall_f, stall_d, stall_e,
    input  flush_d, flush_e, flush_m,
    input  md_start, md_abort, md_err
  );

  modport slave (
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt,
`endif
    input  rs_d, rt_d, rs_e, rt_e,
    input  wreg_e, wreg_m, wreg_w,
    input  regwr_e, regwr_m, regwr_w,
    input  memtoreg_e, memtoreg_m,
    input  branch_d, taken_d,
    input  md_op_e, md_done, exc_m,
    output fwd_a_d, fwd_b_d,
    output fwd_a_e, fwd_b_e,
    output stall_f, stall_d, stall_e,
    output flush_d, flush_e, flush_m,
    output md_start, md_abort, md_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage hazard/forwarding control with mul/div sequencer.
// HAZ_PERF_CNT_EN adds a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  localparam int TW = $clog2(MD_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic          r_md_err;
  logic          w_timeout;
  logic          w_start;
  logic          w_abort;
  logic          w_mdstall;
  logic          w_stall;
  logic          w_lw;
  logic          w_br;
  logic          w_m_rse;
  logic          w_m_rte;
  logic          w_w_rse;
  logic          w_w_rte;
  logic          w_e_src;
  logic          w_m_src;

  assign w_m_rse = hz.regwr_m && hz.wreg_m != '0
                && hz.wreg_m == hz.rs_e;
  assign w_m_rte = hz.regwr_m && hz.wreg_m != '0
                && hz.wreg_m == hz.rt_e;
  assign w_w_rse = hz.regwr_w && hz.wreg_w != '0
                && hz.wreg_w == hz.rs_e;
  assign w_w_rte = hz.regwr_w && hz.wreg_w != '0
                && hz.wreg_w == hz.rt_e;

  assign hz.fwd_a_e = w_m_rse ? 2'b10 :
                      w_w_rse ? 2'b01 : 2'b00;
  assign hz.fwd_b_e = w_m_rte ? 2'b10 :
                      w_w_rte ? 2'b01 : 2'b00;

  assign hz.fwd_a_d = hz.regwr_m && hz.wreg_m != '0
                   && hz.wreg_m == hz.rs_d;
  assign hz.fwd_b_d = hz.regwr_m && hz.wreg_m != '0
                   && hz.wreg_m == hz.rt_d;

  assign w_lw = hz.memtoreg_e
             && (hz.rt_e == hz.rs_d || hz.rt_e == hz.rt_d);

  assign w_e_src = hz.regwr_e && hz.wreg_e != '0
                && (hz.wreg_e == hz.rs_d || hz.wreg_e == hz.rt_d);
  assign w_m_src = hz.memtoreg_m && hz.wreg_m != '0
                && (hz.wreg_m == hz.rs_d || hz.wreg_m == hz.rt_d);
  assign w_br = hz.branch_d && (w_e_src || w_m_src);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_md_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != S_WAIT)
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;
      if (w_timeout)
        r_md_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_mdstall   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (hz.md_op_e && !hz.exc_m) begin
          w_state_nxt = S_WAIT;
          w_start     = 1'b1;
          w_mdstall   = 1'b1;
        end
      end
      S_WAIT: begin
        w_mdstall = 1'b1;
        if (hz.exc_m) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (hz.md_done) begin
          w_state_nxt = S_DONE;
        end else if (r_timer == T_LAST) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_stall     = w_lw | w_br | w_mdstall;
    hz.stall_f  = w_stall;
    hz.stall_d  = w_stall;
    hz.stall_e  = w_mdstall;
    hz.flush_d  = hz.taken_d & ~w_stall;
    hz.flush_e  = (w_lw | w_br) & ~w_mdstall;
    hz.flush_m  = w_mdstall;
    hz.md_start = w_start;
    hz.md_abort = w_abort;

    // an M-stage exception squashes everything younger at once
    if (hz.exc_m) begin
      hz.stall_f = 1'b0;
      hz.stall_d = 1'b0;
      hz.stall_e = 1'b0;
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
      hz.flush_m = 1'b1;
    end

    if (rst) begin
      hz.stall_f  = 1'b0;
      hz.stall_d  = 1'b0;
      hz.stall_e  = 1'b0;
      hz.flush_d  = 1'b0;
      hz.flush_e  = 1'b0;
      hz.flush_m  = 1'b0;
      hz.md_start = 1'b0;
      hz.md_abort = 1'b0;
    end
  end

  assign hz.md_err = r_md_err;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (hz.stall_f && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign hz.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stalls, flushes,
// mul/div handshake, abort and timeout (MD_TIMEOUT=8).
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_st;
  int   n_go;

  hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) hz ();

  hazard_ctrl #(
    .REG_W(5),
    .MD_TIMEOUT(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz.rs_d = '0; hz.rt_d = '0;
    hz.rs_e = '0; hz.rt_e = '0;
    hz.wreg_e = '0; hz.wreg_m = '0;
    hz.wreg_w = '0;
    hz.regwr_e = 0; hz.regwr_m = 0;
    hz.regwr_w = 0;
    hz.memtoreg_e = 0;
    hz.memtoreg_m = 0;
    hz.branch_d = 0; hz.taken_d = 0;
    hz.md_op_e = 0; hz.md_done = 0;
    hz.exc_m = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr();
    rst = 1'b1;
    hz.md_op_e = 1;
    hz.taken_d = 1;
    #12;
    chk("rst_stall_f", 8'(hz.stall_f), 8'h0);
    chk("rst_flush_d", 8'(hz.flush_d), 8'h0);
    chk("rst_start", 8'(hz.md_start), 8'h0);
    chk("rst_err", 8'(hz.md_err), 8'h0);
    clr();
    tick();
    rst = 1'b0;
    tick();

    // load-use: lw r2 in E, add r3,r2,r4 in D
    hz.memtoreg_e = 1; hz.regwr_e = 1;
    hz.wreg_e = 2; hz.rt_e = 2;
    hz.rs_d = 2; hz.rt_d = 4;
    #1;
    chk("lw_stall_f", 8'(hz.stall_f), 8'h1);
    chk("lw_stall_d", 8'(hz.stall_d), 8'h1);
    chk("lw_flush_e", 8'(hz.flush_e), 8'h1);
    chk("lw_stall_e", 8'(hz.stall_e), 8'h0);
    chk("lw_flush_m", 8'(hz.flush_m), 8'h0);
    tick();
    clr();
    hz.rs_e = 2; hz.rt_e = 4;
    hz.regwr_w = 1; hz.wreg_w = 2;
    #1;
    chk("lw_fwd_a_e", 8'(hz.fwd_a_e), 8'h1);
    chk("lw_fwd_b_e", 8'(hz.fwd_b_e), 8'h0);
    chk("lw_released", 8'(hz.stall_f), 8'h0);

    // M beats W
    tick();
    clr();
    hz.regwr_m = 1; hz.wreg_m = 5;
    hz.regwr_w = 1; hz.wreg_w = 5;
    hz.rs_e = 5; hz.rt_e = 5;
    #1;
    chk("prio_a", 8'(hz.fwd_a_e), 8'h2);
    chk("prio_b", 8'(hz.fwd_b_e), 8'h2);
    hz.wreg_w = 6; hz.rt_e = 6;
    #1;
    chk("w_only_b", 8'(hz.fwd_b_e), 8'h1);

    // r0 never forwards
    hz.wreg_m = 0; hz.rs_e = 0;
    hz.wreg_w = 0; hz.rt_e = 0;
    #1;
    chk("r0_a_e", 8'(hz.fwd_a_e), 8'h0);
    chk("r0_b_e", 8'(hz.fwd_b_e), 8'h0);

    // D compare forwarding
    hz.wreg_m = 3; hz.rs_d = 3; hz.rt_d = 1;
    #1;
    chk("fwd_a_d", 8'(hz.fwd_a_d), 8'h1);
    chk("fwd_b_d", 8'(hz.fwd_b_d), 8'h0);

    // branch compare hazards
    tick();
    clr();
    hz.branch_d = 1; hz.taken_d = 1;
    hz.regwr_e = 1; hz.wreg_e = 3;
    hz.rs_d = 3; hz.rt_d = 1;
    #1;
    chk("br_e_stall", 8'(hz.stall_d), 8'h1);
    chk("br_e_flush_e", 8'(hz.flush_e), 8'h1);
    chk("br_e_flush_d", 8'(hz.flush_d), 8'h0);
    hz.regwr_e = 0;
    hz.memtoreg_m = 1; hz.wreg_m = 1;
    #1;
    chk("br_m_stall", 8'(hz.stall_f), 8'h1);
    hz.memtoreg_m = 0;
    #1;
    chk("br_ok_stall", 8'(hz.stall_f), 8'h0);
    chk("br_ok_flush_d", 8'(hz.flush_d), 8'h1);
    chk("br_ok_flush_e", 8'(hz.flush_e), 8'h0);

    // md_done while IDLE is ignored
    tick();
    clr();
    hz.md_done = 1;
    tick();
    hz.md_done = 0;
    tick();

    // mul/div, done 4 cycles after start
    n_st = 0;
    n_go = 0;
    for (int c = 0; c < 7; c++) begin
      hz.md_op_e = (c <= 5);
      hz.md_done = (c == 4);
      #1;
      n_st += int'(hz.stall_e);
      n_go += int'(hz.md_start);
      if (c == 0) begin
        chk("md_c0_start", 8'(hz.md_start), 8'h1);
        chk("md_c0_flush_m", 8'(hz.flush_m), 8'h1);
        chk("md_c0_flush_e", 8'(hz.flush_e), 8'h0);
      end
      if (c == 4)
        chk("md_c4_stall_e", 8'(hz.stall_e), 8'h1);
      if (c == 5) begin
        chk("md_done_stall_e", 8'(hz.stall_e), 8'h0);
        chk("md_done_flush_m", 8'(hz.flush_m), 8'h0);
      end
      tick();
    end
    chk("md_stall_cycles", 8'(n_st), 8'd5);
    chk("md_start_pulses", 8'(n_go), 8'd1);

    // exception aborts WAIT
    clr();
    hz.md_op_e = 1;
    tick();
    chk("exc_pre_stall", 8'(hz.stall_e), 8'h1);
    hz.exc_m = 1;
    #1;
    chk("exc_abort", 8'(hz.md_abort), 8'h1);
    chk("exc_flush_d", 8'(hz.flush_d), 8'h1);
    chk("exc_flush_e", 8'(hz.flush_e), 8'h1);
    chk("exc_flush_m", 8'(hz.flush_m), 8'h1);
    chk("exc_stall_f", 8'(hz.stall_f), 8'h0);
    chk("exc_stall_e", 8'(hz.stall_e), 8'h0);
    tick();
    clr();
    #1;
    chk("exc_idle", 8'(hz.stall_e), 8'h0);
    chk("exc_abort_off", 8'(hz.md_abort), 8'h0);

    // timeout after 8 WAIT cycles
    n_st = 0;
    for (int c = 0; c < 9; c++) begin
      hz.md_op_e = 1;
      #1;
      n_st += int'(hz.stall_e);
      tick();
    end
    chk("to_err_early", 8'(hz.md_err), 8'h1);
    chk("to_stall_cycles", 8'(n_st), 8'd9);
    clr();
    #1;
    chk("to_released", 8'(hz.stall_e), 8'h0);
    tick();
    chk("to_err_sticky", 8'(hz.md_err), 8'h1);

    // reset in the middle of WAIT
    hz.md_op_e = 1;
    tick();
    tick();
    chk("rw_pre_stall", 8'(hz.stall_e), 8'h1);
    rst = 1'b1;
    #1;
    chk("rw_err_clr", 8'(hz.md_err), 8'h0);
    chk("rw_stall_e", 8'(hz.stall_e), 8'h0);
    tick();
    hz.md_op_e = 0;
    rst = 1'b0;
    #1;
    chk("rw_idle", 8'(hz.stall_e), 8'h0);
    chk("rw_err_after", 8'(hz.md_err), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
